// File: rtl/encoder_4_to_2_rr.sv
// Sequential 4-to-2 request encoder: captures request pulses into a pending set and
// presents them one at a time as 2-bit codes over valid/ready, round-robin order.
module encoder_4_to_2_rr (
   input  logic       clk,
   input  logic       rst,
   input  logic       E,
   input  logic [3:0] D,
   input  logic       R,
   output logic [1:0] A,
   output logic       V,
   output logic [3:0] P,
   output logic       OVF
);

   logic [1:0] ptr;
   logic [1:0] g;
   logic       found;
   logic       load;
   logic [3:0] set;
   logic [3:0] clr;
   logic [3:0] p_nxt;
   logic       ovf_hit;

   assign set  = D & {4{E}};
   assign load = ~V | R;

   // Round-robin search starting at ptr; the first pending bit wins.
   always_comb begin
      logic [1:0] idx;
      g     = ptr;
      found = 1'b0;
      idx   = ptr;
      for (int k = 0; k < 4; k++) begin
         idx = ptr + 2'(k);
         if (!found && P[idx]) begin
            g     = idx;
            found = 1'b1;
         end
      end
   end

   always_comb begin
      clr = 4'b0000;
      if (load && found) clr[g] = 1'b1;
   end

   // Set wins over clear, so a re-request on the grant edge stays pending.
   assign p_nxt   = (P & ~clr) | set;
   assign ovf_hit = |(set & P & ~clr);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         A   <= 2'b00;
         V   <= 1'b0;
         P   <= 4'b0000;
         OVF <= 1'b0;
         ptr <= 2'b00;
      end else begin
         P <= p_nxt;
         if (ovf_hit) OVF <= 1'b1;
         if (load) begin
            if (found) begin
               A   <= g;
               V   <= 1'b1;
               ptr <= g + 2'd1;
            end else begin
               V <= 1'b0;
            end
         end
      end
   end

endmodule
